// File: rtl/fcpu_pkg.sv
// Shared core types: 2-bit saturating branch counter encoding and its update rule.
package fcpu_pkg;

  localparam int CRAM_ADDR_W = 16;

  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_ctr_t;

  localparam bp_ctr_t BP_CTR_RESET = BP_WNT;

  function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t ctr, input logic taken);
    bp_ctr_t nxt;
    case (ctr)
      BP_SNT:  nxt = taken ? BP_WNT : BP_SNT;
      BP_WNT:  nxt = taken ? BP_WT  : BP_SNT;
      BP_WT:   nxt = taken ? BP_ST  : BP_WNT;
      BP_ST:   nxt = taken ? BP_ST  : BP_WT;
      default: nxt = BP_CTR_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Flop array of 2-bit direction counters: one async read port, one read-modify-write
// update port that applies the saturating step to the entry's current value.
module bp_counter_table
  import fcpu_pkg::*;
#(
  parameter int TABLE_BITS = 6
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [TABLE_BITS-1:0] rd_idx,
  output logic [1:0]            rd_ctr,
  input  logic                  wr_en,
  input  logic [TABLE_BITS-1:0] wr_idx,
  input  logic                  wr_taken
);

  localparam int ENTRIES = 1 << TABLE_BITS;

  bp_ctr_t ctr_r [ENTRIES];

  // Counter storage; updates read the entry's stored value so back-to-back updates chain.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_r[i] <= BP_CTR_RESET;
      end
    end else if (wr_en) begin
      ctr_r[wr_idx] <= bp_ctr_next(ctr_r[wr_idx], wr_taken);
    end
  end

  // No bypass: a same-cycle lookup sees the pre-update value.
  assign rd_ctr = ctr_r[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Bimodal/gshare direction predictor with resolve-time training and hit/miss statistics.
// Define BP_GSHARE_EN to XOR a non-speculative global history register into both indices.
module branch_predictor
  import fcpu_pkg::*;
#(
  parameter int TABLE_BITS = 6,
  parameter int STAT_W     = 32
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   ce,
  input  logic [CRAM_ADDR_W-1:0] lookup_pc,
  output logic                   take_flag,
  input  logic                   res_valid,
  input  logic [CRAM_ADDR_W-1:0] res_pc,
  input  logic                   res_taken,
  input  logic                   res_pred,
  input  logic                   stat_clr,
  output logic [STAT_W-1:0]      stat_total,
  output logic [STAT_W-1:0]      stat_miss
);

  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};
  localparam logic [STAT_W-1:0] STAT_ZERO = {STAT_W{1'b0}};

  logic [TABLE_BITS-1:0] li_s;
  logic [TABLE_BITS-1:0] ui_s;
  logic [TABLE_BITS-1:0] rd_idx_s;
  logic [TABLE_BITS-1:0] wr_idx_s;
  logic [1:0]            rd_ctr_s;
  logic                  upd_s;
  logic                  unused_pc_s;
  logic [STAT_W-1:0]     stat_total_r;
  logic [STAT_W-1:0]     stat_miss_r;

  // Fetch addresses are word aligned, so the two low bits carry no index information.
  assign li_s  = lookup_pc[TABLE_BITS+1:2];
  assign ui_s  = res_pc[TABLE_BITS+1:2];
  assign upd_s = ce & res_valid;
  assign unused_pc_s = ^{lookup_pc[CRAM_ADDR_W-1:TABLE_BITS+2], lookup_pc[1:0],
                         res_pc[CRAM_ADDR_W-1:TABLE_BITS+2], res_pc[1:0], rd_ctr_s[0]};

`ifdef BP_GSHARE_EN
  logic [TABLE_BITS-1:0] ghr_r;

  // Global history; only resolved outcomes shift in, and the table update uses the pre-shift value.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ghr_r <= {TABLE_BITS{1'b0}};
    end else if (upd_s) begin
      ghr_r <= {ghr_r[TABLE_BITS-2:0], res_taken};
    end
  end

  assign rd_idx_s = li_s ^ ghr_r;
  assign wr_idx_s = ui_s ^ ghr_r;
`else
  assign rd_idx_s = li_s;
  assign wr_idx_s = ui_s;
`endif

  bp_counter_table #(
    .TABLE_BITS (TABLE_BITS)
  ) u_table (
    .clk      (clk),
    .nrst     (nrst),
    .rd_idx   (rd_idx_s),
    .rd_ctr   (rd_ctr_s),
    .wr_en    (upd_s),
    .wr_idx   (wr_idx_s),
    .wr_taken (res_taken)
  );

  assign take_flag = rd_ctr_s[1];

  // Saturating statistics; clear wins over a same-cycle resolution.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stat_total_r <= STAT_ZERO;
      stat_miss_r  <= STAT_ZERO;
    end else if (ce) begin
      if (stat_clr) begin
        stat_total_r <= STAT_ZERO;
        stat_miss_r  <= STAT_ZERO;
      end else if (res_valid) begin
        if (stat_total_r != STAT_MAX) begin
          stat_total_r <= stat_total_r + STAT_ONE;
        end
        if ((res_pred != res_taken) && (stat_miss_r != STAT_MAX)) begin
          stat_miss_r <= stat_miss_r + STAT_ONE;
        end
      end
    end
  end

  assign stat_total = stat_total_r;
  assign stat_miss  = stat_miss_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: behavioural counter-table model, per-cycle compare, directed and random stimulus.
module tb_branch_predictor;
  import fcpu_pkg::*;

  localparam int TBITS = 6;
  localparam int SW    = 8;
  localparam int N     = 1 << TBITS;
  localparam int SMAX  = (1 << SW) - 1;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  logic ce = 1'b0;
  logic res_valid = 1'b0;
  logic res_taken = 1'b0;
  logic res_pred = 1'b0;
  logic stat_clr = 1'b0;
  logic [CRAM_ADDR_W-1:0] lookup_pc = '0;
  logic [CRAM_ADDR_W-1:0] res_pc = '0;
  logic take_flag;
  logic [SW-1:0] stat_total;
  logic [SW-1:0] stat_miss;

  int checks = 0;
  int failures = 0;
  int m_ctr [N];
  int m_total;
  int m_miss;
  int m_ghr;
  int t0;
  int x0;

  always #5 clk = ~clk;

  branch_predictor #(.TABLE_BITS(TBITS), .STAT_W(SW)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .ce         (ce),
    .lookup_pc  (lookup_pc),
    .take_flag  (take_flag),
    .res_valid  (res_valid),
    .res_pc     (res_pc),
    .res_taken  (res_taken),
    .res_pred   (res_pred),
    .stat_clr   (stat_clr),
    .stat_total (stat_total),
    .stat_miss  (stat_miss)
  );

  function automatic int idx_of(input logic [CRAM_ADDR_W-1:0] pc);
    int i;
    i = (int'(pc) / 4) % N;
`ifdef BP_GSHARE_EN
    i = i ^ m_ghr;
`endif
    return i;
  endfunction

  function automatic int m_pred(input logic [CRAM_ADDR_W-1:0] pc);
    return (m_ctr[idx_of(pc)] >= 2) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_ctr[i] = 1;
    m_total = 0;
    m_miss  = 0;
    m_ghr   = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge nrst) model_reset();

  // Reference model: counters as integers 0..3, statistics as clamped integers
  always @(posedge clk) begin
    if (nrst && ce) begin
      if (res_valid) begin
        int k;
        k = idx_of(res_pc);
        if (res_taken) m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
        else           m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
`ifdef BP_GSHARE_EN
        m_ghr = (m_ghr * 2 + int'(res_taken)) % N;
`endif
      end
      if (stat_clr) begin
        m_total = 0;
        m_miss  = 0;
      end else if (res_valid) begin
        if (m_total < SMAX) m_total++;
        if (res_pred != res_taken && m_miss < SMAX) m_miss++;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_take_flag", int'(take_flag), m_pred(lookup_pc));
    check("cyc_stat_total", int'(stat_total), m_total);
    check("cyc_stat_miss", int'(stat_miss), m_miss);
  end

  initial begin
    model_reset();
    #1 nrst = 1'b0;
    #12 nrst = 1'b1;
    tick();
    ce = 1'b1;

    lookup_pc = 16'h0000; #1 check("rst_pc000", int'(take_flag), 0);
    lookup_pc = 16'h00FC; #1 check("rst_pc0fc", int'(take_flag), 0);
    lookup_pc = 16'h0100; #1 check("rst_pc100", int'(take_flag), 0);
    check("rst_total", int'(stat_total), 0);
    check("rst_miss", int'(stat_miss), 0);
    tick();

`ifndef BP_GSHARE_EN
    lookup_pc = 16'h0010; res_pc = 16'h0010; res_valid = 1'b1; res_taken = 1'b1; res_pred = 1'b0;
    #1 check("train_pre", int'(take_flag), 0);
    tick();
    check("train_after1", int'(take_flag), 1);
    tick();
    res_valid = 1'b0;
    #1 check("train_after2", int'(take_flag), 1);
    check("train_total", int'(stat_total), 2);
    check("train_miss", int'(stat_miss), 2);
    res_pred = 1'b1; res_valid = 1'b1;
    repeat (4) tick();
    res_taken = 1'b0;
    tick();
    res_valid = 1'b0;
    #1 check("tnt_pred", int'(take_flag), 1);
    check("tnt_model_ctr", m_ctr[4], 2);
    check("tnt_miss", int'(stat_miss), 3);

    res_pc = 16'h0004; res_taken = 1'b1; res_valid = 1'b1;
    repeat (2) tick();
    res_valid = 1'b0; lookup_pc = 16'h0104;
    #1 check("alias_104", int'(take_flag), 1);

    lookup_pc = 16'h0020; res_pc = 16'h0020; res_taken = 1'b1; res_valid = 1'b1;
    #1 check("same_cyc_pre", int'(take_flag), 0);
    tick();
    res_valid = 1'b0;
    #1 check("same_cyc_post", int'(take_flag), 1);
`else
    lookup_pc = 16'h0010; res_pc = 16'h0010; res_taken = 1'b1; res_pred = 1'b0; res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    check("gs_ghr", m_ghr, 1);
    #1 check("gs_pc010_entry5", int'(take_flag), 0);
    check("gs_model_entry4", m_ctr[4], 2);
    lookup_pc = 16'h0014;
    #1 check("gs_entry4_pred", int'(take_flag), 1);
`endif
    tick();

    ce = 1'b0; res_pc = 16'h0030; lookup_pc = 16'h0030; res_valid = 1'b1; res_taken = 1'b1;
    t0 = m_total; x0 = m_miss;
    repeat (5) tick();
    check("freeze_total", int'(stat_total), t0);
    check("freeze_miss", int'(stat_miss), x0);
    check("freeze_pred", int'(take_flag), 0);

    ce = 1'b1; stat_clr = 1'b1; res_pred = 1'b0;
    tick();
    stat_clr = 1'b0; res_valid = 1'b0;
    #1 check("clr_total", int'(stat_total), 0);
    check("clr_miss", int'(stat_miss), 0);

    res_valid = 1'b1;
    for (int i = 0; i < SMAX + 5; i++) begin
      res_pc = 16'($urandom_range(0, 63)) << 2;
      res_taken = 1'($urandom_range(0, 1));
      res_pred = ~res_taken;
      tick();
    end
    res_valid = 1'b0;
    #1 check("sat_total", int'(stat_total), SMAX);
    check("sat_miss", int'(stat_miss), SMAX);
    res_valid = 1'b1; res_taken = 1'b1; res_pred = 1'b0;
    tick();
    res_valid = 1'b0;
    #1 check("sat_hold_total", int'(stat_total), SMAX);
    check("sat_hold_miss", int'(stat_miss), SMAX);

    res_pc = 16'h0040; lookup_pc = 16'h0040; res_taken = 1'b1; res_valid = 1'b1;
    tick();
    tick();
    #1 nrst = 1'b0;
    #1 check("async_rst_take", int'(take_flag), 0);
    check("async_rst_total", int'(stat_total), 0);
    check("async_rst_miss", int'(stat_miss), 0);
    @(negedge clk);
    #2 nrst = 1'b1;
    tick();
    res_valid = 1'b0;
    #1 check("post_rst_total", int'(stat_total), 1);

    repeat (3000) begin
      ce        = ($urandom_range(0, 9) != 0);
      res_valid = 1'($urandom_range(0, 1));
      res_pc    = 16'($urandom_range(0, 1023));
      lookup_pc = 16'($urandom_range(0, 1023));
      res_taken = 1'($urandom_range(0, 1));
      res_pred  = 1'($urandom_range(0, 1));
      stat_clr  = ($urandom_range(0, 63) == 0);
      tick();
    end
    res_valid = 1'b0;
    stat_clr  = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
